// File: rtl/fir_pkg.sv
// Shared types, widths and helpers for the time-multiplexed FIR tap sequencer.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, DONE} fir_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int sat_hi(input int wlp);
    return (1 << (wlp - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int wlp);
    return -(1 << (wlp - 1));
  endfunction

  localparam int FIR_WL     = 4;
  localparam int FIR_WLC    = 4;
  localparam int FIR_NTAPS  = 3;
  localparam int FIR_WLP    = FIR_WL + FIR_WLC;
  localparam int FIR_WLA    = FIR_WLP + clog2(FIR_NTAPS);
  localparam int FIR_SAT_HI = sat_hi(FIR_WLP);
  localparam int FIR_SAT_LO = sat_lo(FIR_WLP);

endpackage

// File: rtl/fir_mac.sv
// Shared multiplier-accumulator: combinational signed product, registered running sum.
module fir_mac #(
  parameter int WL  = 4,
  parameter int WLC = 4,
  parameter int WLA = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  en,
  input  logic signed [WL-1:0]  a,
  input  logic signed [WLC-1:0] b,
  output logic signed [WLA-1:0] sum
);

  localparam int WLP = WL + WLC;

  logic signed [WLP-1:0] prod;
  logic signed [WLA-1:0] acc;

  assign prod = WLP'(a) * WLP'(b);
  assign sum  = acc + WLA'(prod);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR: one MAC per tap, delay line and coefficient file held here.
// Define FIR_TAP_SEQ_SAT_EN to clamp y to the signed WL+WLC-bit range.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter  int WL    = FIR_WL,
  parameter  int WLC   = FIR_WLC,
  parameter  int NTAPS = FIR_NTAPS,
  localparam int AW    = clog2(NTAPS),
  localparam int WLP   = WL + WLC,
  localparam int WLA   = WLP + AW
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  x_valid,
  input  logic signed [WL-1:0]  x,
  output logic                  x_ready,
  input  logic                  coef_we,
  input  logic [AW-1:0]         coef_addr,
  input  logic signed [WLC-1:0] coef_data,
  output logic                  y_valid,
  output logic signed [WLA-1:0] y,
  output logic                  busy
);

  fir_state_t            state;
  logic [AW-1:0]         k;
  logic signed [WL-1:0]  d [NTAPS];
  logic signed [WLC-1:0] c [NTAPS];
  logic signed [WLA-1:0] sum;
  logic signed [WLA-1:0] y_next;
  logic                  accept;
  logic                  last;

  assign x_ready = (state == IDLE);
  assign busy    = (state != IDLE);
  assign accept  = x_valid && x_ready;
  assign last    = (int'(k) == NTAPS - 1);

  fir_mac #(.WL(WL), .WLC(WLC), .WLA(WLA)) u_mac (
    .CLK (CLK),
    .RST (RST),
    .clr (accept),
    .en  (state == MAC),
    .a   (d[k]),
    .b   (c[k]),
    .sum (sum)
  );

`ifdef FIR_TAP_SEQ_SAT_EN
  localparam logic signed [WLA-1:0] SAT_HI = WLA'(sat_hi(WLP));
  localparam logic signed [WLA-1:0] SAT_LO = WLA'(sat_lo(WLP));

  always_comb begin
    y_next = sum;
    if (sum > SAT_HI)      y_next = SAT_HI;
    else if (sum < SAT_LO) y_next = SAT_LO;
  end
`else
  assign y_next = sum;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      k       <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          // a write on the accept edge lands before the first MAC reads c[]
          if (coef_we && int'(coef_addr) < NTAPS) c[coef_addr] <= coef_data;
          if (accept) begin
            d[0] <= x;
            for (int unsigned i = 1; i < NTAPS; i++) d[i] <= d[i-1];
            k     <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          k <= k + 1'b1;
          if (last) begin
            y       <= y_next;
            y_valid <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          y_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Time-multiplexed controller for the team's signed FIR filter. One multiplier-accumulator is shared across all NTAPS taps instead of one multiplier per tap. The block owns the sample delay line and the coefficient register file. It accepts samples over a valid/ready handshake, sequences one MAC per tap, and emits one filtered output per accepted sample. It sits between the sample source and the downstream consumer, in place of the fully parallel FIR.

Parameters:
WL, 4, input sample width (signed two's complement)
WLC, 4, coefficient width (signed two's complement)
NTAPS, 3, number of taps; legal range 2..16
(derived, not overridable) WLA = WL+WLC+clog2(NTAPS), accumulator and output width; 10 at the defaults

Ports:
CLK  in  1  rising-edge clock
RST  in  1  asynchronous, active-high reset
x_valid  in  1  sample offered
x  in  WL  signed input sample
x_ready  out  1  sequencer can accept a sample
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(NTAPS)  tap index to write
coef_data  in  WLC  signed coefficient value
y_valid  out  1  one-cycle pulse, y holds a new result
y  out  WLA  signed filter output; holds its value between pulses
busy  out  1  high in the MAC and DONE states

Behaviour:
- Reset (async assert, sync release): state=IDLE; delay line d[0..NTAPS-1]=0; coef c[0..NTAPS-1]=0; acc=0; y=0; y_valid=0; busy=0; x_ready=1.
- x_ready = (state==IDLE), driven combinationally from the state register. busy = (state!=IDLE).
- FSM IDLE:
  - on x_valid && x_ready at edge t: d[0]<=x, d[i]<=d[i-1]; acc<=0; k<=0; go to MAC.
  - x_valid with no handshake leaves the delay line unchanged.
- FSM MAC:
  - each edge: acc<=acc+sext(d[k])*sext(c[k]); k<=k+1.
  - on the edge with k==NTAPS-1: y<=final sum, y_valid<=1, go to DONE.
- FSM DONE: next edge y_valid<=0, go to IDLE.
- Timing:
  - y_valid is high for exactly one cycle, starting NTAPS edges after the accept edge.
  - next accept is no earlier than edge t+NTAPS+2 (interval 5 at the defaults).
- Arithmetic:
  - full-precision signed multiply, sign-extended to WLA before accumulating.
  - no truncation; WLA guarantees no overflow.
- Coefficient writes:
  - committed only in IDLE; coef_we in MAC or DONE is silently dropped.
  - coef_addr>=NTAPS is ignored.
  - a write in the same IDLE cycle as an accepted sample is committed at that edge and used by that sample's MAC.
- Reset mid-operation: aborts immediately; no y_valid is produced; the delay line and coefficients are cleared.
- x is sampled only on the handshake edge; changes to x during MAC have no effect.

Optional Feature:
- Macro FIR_TAP_SEQ_SAT_EN.
- Defined: y is clamped to the signed WL+WLC-bit range [-2^(WL+WLC-1), 2^(WL+WLC-1)-1], then sign-extended to WLA. acc itself is never clamped.
- Undefined: y = acc unmodified. Port list is identical in both builds.

Decomposition:
- Package fir_pkg holds:
  - state enum {IDLE, MAC, DONE};
  - a clog2 constant function;
  - width localparams (WLA, WLP=WL+WLC);
  - the sat-limit constants.
- One sub-module, fir_mac: a combinational signed multiply plus registered accumulate with a clear input.
- The FSM, delay line and coefficient file live in fir_tap_sequencer.

Test Plan:
All scenarios use the defaults (WL=4, WLC=4, NTAPS=3).
1. Reset check: assert RST mid-MAC -> y_valid stays 0 and y=0; x_ready=1 on release; no stale result afterwards.
2. Impulse and known-answer check: load c={1,2,-1}, then push x=-1,-2,3,4 -> y=-1,-4,0,12. Each y_valid arrives exactly 3 edges after its accept edge.
3. Backpressure: hold x_valid=1 continuously with a changing x -> accepts exactly every 5 cycles. x_ready is low in MAC and DONE. No sample is duplicated or skipped, checked against a golden model.
4. Coefficient write hazards:
   - write c[0]=7 during MAC -> current and next results still use c[0]=1.
   - coef_addr=3 -> no coefficient changes.
   - write plus accept in the same IDLE cycle -> the new value is used.
5. Extremes: all c=-8, push x=-8 three times -> third y=192. With FIR_TAP_SEQ_SAT_EN defined -> y=127.
